// File: rtl/ring_buf_pkg.sv
// rtl/ring_buf_pkg.sv - shared defaults and pointer/count width helpers for pixel_ring_buffer
package ring_buf_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_RESET = 0;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

  localparam int DEFAULT_PTR_W = ptr_width(DEFAULT_DEPTH);
  localparam int DEFAULT_CNT_W = count_width(DEFAULT_DEPTH);

  typedef logic [DEFAULT_PTR_W-1:0] ptr_t;
  typedef logic [DEFAULT_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/ring_ptr.sv
// rtl/ring_ptr.sv - wrapping pointer counter with clear and increment
module ring_ptr
  import ring_buf_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int PW = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clear,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  // DEPTH is a power of two, so wrapping is plain binary overflow.
  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PW'(1);
    end
  end

endmodule

// File: rtl/pixel_ring_buffer.sv
// rtl/pixel_ring_buffer.sv - circular pixel FIFO with occupancy count; RING_PEEK_EN adds random-access peek
module pixel_ring_buffer
  import ring_buf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET = WIDTH'(DEFAULT_RESET),
  localparam int PW = ptr_width(DEPTH),
  localparam int CW = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef RING_PEEK_EN
  input  logic [PW-1:0]    peek_idx,
  output logic [WIDTH-1:0] peek_data,
  output logic             peek_valid,
`endif
  output logic [CW-1:0]    count
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("pixel_ring_buffer: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Handshake outputs come only from the count register, never from in_valid/out_ready.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  ring_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  ring_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET;
      end
    end else if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CW'(1);
    end else if (pop && !push) begin
      count <= count - CW'(1);
    end
  end

`ifdef RING_PEEK_EN
  logic [PW-1:0] peek_ptr;

  assign peek_ptr   = rd_ptr + peek_idx;
  assign peek_data  = mem[peek_ptr];
  assign peek_valid = ({1'b0, peek_idx} < count);
`endif

endmodule

// File: tb/tb_pixel_ring_buffer.sv
// tb/tb_pixel_ring_buffer.sv - scoreboard bench for pixel_ring_buffer (DEPTH=4, WIDTH=8, RESET=2)
module tb_pixel_ring_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam logic [WIDTH-1:0] RST_VAL = 8'd2;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       count;
`ifdef RING_PEEK_EN
  logic [1:0]       peek_idx;
  logic [WIDTH-1:0] peek_data;
  logic             peek_valid;
`endif

  int errors = 0;
  int checks = 0;
  int mcount = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  pixel_ring_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET(RST_VAL)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
`ifdef RING_PEEK_EN
    .peek_idx   (peek_idx),
    .peek_data  (peek_data),
    .peek_valid (peek_valid),
`endif
    .count      (count)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop is compared against the head of the expected queue.
  always @(negedge clk) begin
    if (n_rst && !clear && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 1, 0);
      end else begin
        check("pop_data", int'(out_data), int'(exp_q.pop_front()));
      end
    end
  end

  // One clock: drive inputs, advance the bench's own occupancy model, then check count.
  task automatic cycle(input logic iv, input logic [WIDTH-1:0] d, input logic ordy,
                       input logic clr, input string name);
    bit p_push, p_pop;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    p_push    = iv && (mcount != DEPTH);
    p_pop     = ordy && (mcount != 0);
    if (clr) begin
      mcount = 0;
      exp_q.delete();
    end else begin
      if (p_push) exp_q.push_back(d);
      mcount = mcount + (p_push ? 1 : 0) - (p_pop ? 1 : 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear     = 1'b0;
    check(name, int'(count), mcount);
  endtask

  initial begin
    n_rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
`ifdef RING_PEEK_EN
    peek_idx = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    check("rst_count", int'(count), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_data", int'(out_data), 2);
`ifdef RING_PEEK_EN
    check("rst_peek_data", int'(peek_data), 2);
    check("rst_peek_valid", int'(peek_valid), 0);
`endif

    begin
      logic [WIDTH-1:0] fill [4];
      fill = '{8'hAA, 8'h55, 8'h0F, 8'hF0};
      for (int i = 0; i < 4; i++) cycle(1'b1, fill[i], 1'b0, 1'b0, "fill_count");
    end
    check("full_in_ready", int'(in_ready), 0);
    check("full_out_valid", int'(out_valid), 1);
    cycle(1'b1, 8'h11, 1'b0, 1'b0, "fifth_push_count");
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain_count");
    check("empty_out_valid", int'(out_valid), 0);
    check("empty_in_ready", int'(in_ready), 1);

    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, "refill_count");
    cycle(1'b1, 8'h77, 1'b1, 1'b0, "full_pop_only_count");
    cycle(1'b1, 8'h77, 1'b0, 1'b0, "push_after_pop_count");
    repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0, "to_two_count");

    for (int i = 0; i < 10; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0, "wrap_count");

    cycle(1'b1, 8'hC3, 1'b0, 1'b0, "pre_clear_count");
    cycle(1'b1, 8'hEE, 1'b0, 1'b1, "clear_count");
    check("clear_out_valid", int'(out_valid), 0);
    check("clear_out_data", int'(out_data), 2);

    cycle(1'b1, 8'h10, 1'b0, 1'b0, "peek_fill_count");
    cycle(1'b1, 8'h20, 1'b0, 1'b0, "peek_fill_count");
    cycle(1'b1, 8'h30, 1'b0, 1'b0, "peek_fill_count");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "peek_pop_count");
    check("head_after_pop", int'(out_data), 8'h20);
`ifdef RING_PEEK_EN
    peek_idx = 2'd1;
    #1;
    check("peek1_data", int'(peek_data), 8'h30);
    check("peek1_valid", int'(peek_valid), 1);
    peek_idx = 2'd2;
    #1;
    check("peek2_valid", int'(peek_valid), 0);
`endif

    repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0, "final_drain_count");
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time budget, expected completion");
    $fatal(1);
  end

endmodule
